// File: rtl/rx_buffer_pkg.sv
// Shared types and defaults for the RX slot-buffer write path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rx_buffer_pkg;

    // Write sequencer states.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_RECV,
        RX_LAST,
        RX_COMMIT,
        RX_DROP
    } rx_wr_state_e;

    // Default slot size in bytes (also the largest frame accepted).
    localparam int rx_els_default_lp        = 2048;
    // Default width of the committed frame-size field.
    localparam int rx_size_width_default_lp = 16;
    // Width of the saturating drop counters.
    localparam int rx_drop_cnt_width_lp     = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [rx_drop_cnt_width_lp-1:0] sat_incr(
        input logic [rx_drop_cnt_width_lp-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// Packs a byte stream little-endian into buffer words and emits word writes.
// Latency: a byte that fills a word (or is flushed) produces word_v_o one cycle later.
// Backpressure: none; every pushed byte is absorbed in the cycle it arrives.
//
// Ports:
//   push_i   - accept data_i this cycle
//   start_i  - data_i is the first byte of a frame (count/lane state restart)
//   flush_i  - data_i is the last byte of a good frame; write the partial word
//   kill_i   - suppress any word write caused by this byte
//   count_o  - bytes accepted so far in the current frame
//   word_*_o - registered word write (strobe, byte address, data)
module rx_byte_packer
    import rx_buffer_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int els_p        = rx_els_default_lp
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        push_i,
    input  logic                        start_i,
    input  logic                        flush_i,
    input  logic                        kill_i,
    input  logic [7:0]                  data_i,
    output logic [$clog2(els_p):0]      count_o,
    output logic                        word_v_o,
    output logic [$clog2(els_p)-1:0]    word_addr_o,
    output logic [data_width_p-1:0]     word_data_o
);

    localparam int bytes_per_word_lp = data_width_p / 8;
    localparam int lane_width_lp     = $clog2(bytes_per_word_lp);
    localparam int addr_width_lp     = $clog2(els_p);
    localparam int count_width_lp    = addr_width_lp + 1;
    localparam logic [addr_width_lp-1:0] lane_mask_lp = addr_width_lp'(bytes_per_word_lp - 1);

    logic [count_width_lp-1:0] count_q;
    logic [data_width_p-1:0]   lanes_q;
    logic                      word_v_q;
    logic [addr_width_lp-1:0]  word_addr_q;
    logic [data_width_p-1:0]   word_data_q;

    logic [count_width_lp-1:0] cur_count;
    logic [data_width_p-1:0]   cur_lanes;
    logic [data_width_p-1:0]   nxt_lanes;
    logic [lane_width_lp-1:0]  lane_idx;
    logic                      word_full;
    logic                      emit;

    // A frame start behaves as if count and lanes were already zero, so the
    // first byte lands in lane 0 without needing an idle clearing cycle.
    always_comb begin
        cur_count = start_i ? '0 : count_q;
        cur_lanes = start_i ? '0 : lanes_q;
        lane_idx  = cur_count[lane_width_lp-1:0];
        nxt_lanes = cur_lanes;
        nxt_lanes[lane_idx*8 +: 8] = data_i;
        word_full = (lane_idx == lane_width_lp'(bytes_per_word_lp - 1));
        emit      = push_i && !kill_i && (word_full || flush_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q     <= '0;
            lanes_q     <= '0;
            word_v_q    <= 1'b0;
            word_addr_q <= '0;
            word_data_q <= '0;
        end else begin
            word_v_q <= emit;
            if (push_i) begin
                count_q <= cur_count + 1'b1;
                // Lanes restart at zero after each word so a flushed partial
                // word carries zeros in its unfilled upper lanes.
                lanes_q <= (word_full || flush_i) ? '0 : nxt_lanes;
            end
            if (emit) begin
                word_addr_q <= cur_count[addr_width_lp-1:0] & ~lane_mask_lp;
                word_data_q <= nxt_lanes;
            end
        end
    end

    assign count_o     = count_q;
    assign word_v_o    = word_v_q;
    assign word_addr_o = word_addr_q;
    assign word_data_o = word_data_q;

endmodule

// File: rtl/rx_buffer_write_ctrl.sv
// MAC-side sequencer: packs RX bytes into the current slot, then commits size and slot.
// Latency: word write at byte+1; good frame commits size/slot at last+2, idle again at last+3.
// Backpressure: none toward the MAC; frames that cannot be taken are dropped and counted.
//
// Ports:
//   rx_v_i/rx_data_i/rx_last_i/rx_error_i - MAC byte stream, one byte per cycle max
//   write_slot_ready_and_i                - a free slot exists (sampled on first byte)
//   write_v_o/write_addr_o/write_data_o   - word writes into the current slot
//   write_size_v_o/write_size_o           - frame length write, paired with write_slot_v_o
//   drop_full_count_o / drop_err_count_o  - saturating discard counters
module rx_buffer_write_ctrl
    import rx_buffer_pkg::*;
#(
    parameter int data_width_p = 64,   // 32 or 64
    parameter int els_p        = rx_els_default_lp,
    parameter int size_width_p = rx_size_width_default_lp
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            rx_v_i,
    input  logic [7:0]                      rx_data_i,
    input  logic                            rx_last_i,
    input  logic                            rx_error_i,
    output logic                            write_slot_v_o,
    input  logic                            write_slot_ready_and_i,
    output logic                            write_size_v_o,
    output logic [size_width_p-1:0]         write_size_o,
    output logic                            write_v_o,
    output logic [$clog2(els_p)-1:0]        write_addr_o,
    output logic [data_width_p-1:0]         write_data_o,
    output logic [rx_drop_cnt_width_lp-1:0] drop_full_count_o,
    output logic [rx_drop_cnt_width_lp-1:0] drop_err_count_o
);

    localparam int addr_width_lp  = $clog2(els_p);
    localparam int count_width_lp = addr_width_lp + 1;

    rx_wr_state_e state_q, state_d;
    logic         err_q, err_d;
    logic         pend_q, pend_d;   // a dropped frame began during LAST
    logic         commit_q;
    logic [size_width_p-1:0]         size_q;
    logic [rx_drop_cnt_width_lp-1:0] drop_full_q;
    logic [rx_drop_cnt_width_lp-1:0] drop_err_q;

    logic                      take;
    logic                      start;
    logic                      flush;
    logic                      kill;
    logic                      inc_full;
    logic                      inc_err;
    logic                      oversize;
    logic                      err_frame;
    logic [count_width_lp-1:0] byte_count;

    assign oversize = (byte_count == count_width_lp'(els_p));

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        pend_d    = pend_q;
        take      = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        kill      = 1'b0;
        inc_full  = 1'b0;
        inc_err   = 1'b0;
        // The sticky flag belongs to the previous frame until a new one starts.
        err_frame = (state_q == RX_IDLE) ? rx_error_i : (err_q | rx_error_i);

        unique case (state_q)
            RX_IDLE: begin
                if (rx_v_i) begin
                    if (write_slot_ready_and_i) begin
                        take  = 1'b1;
                        start = 1'b1;
                    end else begin
                        inc_full = 1'b1;
                        state_d  = rx_last_i ? RX_IDLE : RX_DROP;
                    end
                end
            end
            RX_RECV: begin
                if (rx_v_i) begin
                    if (oversize) begin
                        inc_err = 1'b1;
                        state_d = rx_last_i ? RX_IDLE : RX_DROP;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            RX_LAST: begin
                // The good frame still commits; a byte here opens a dropped frame.
                state_d = RX_COMMIT;
                if (rx_v_i) begin
                    inc_full = 1'b1;
                    pend_d   = !rx_last_i;
                end
            end
            RX_COMMIT: begin
                pend_d = 1'b0;
                if (rx_v_i) begin
                    // With pend set this byte continues the frame already counted.
                    inc_full = !pend_q;
                    state_d  = rx_last_i ? RX_IDLE : RX_DROP;
                end else begin
                    state_d  = pend_q ? RX_DROP : RX_IDLE;
                end
            end
            RX_DROP: begin
                if (rx_v_i && rx_last_i) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        if (take) begin
            err_d = err_frame;
            if (rx_last_i) begin
                if (err_frame) begin
                    kill    = 1'b1;
                    inc_err = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    flush   = 1'b1;
                    state_d = RX_LAST;
                end
            end else begin
                state_d = RX_RECV;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= RX_IDLE;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            commit_q    <= 1'b0;
            size_q      <= '0;
            drop_full_q <= '0;
            drop_err_q  <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            // Registered decode of COMMIT: the byte count is final during LAST.
            commit_q <= (state_d == RX_COMMIT);
            if (state_d == RX_COMMIT) begin
                size_q <= size_width_p'(byte_count);
            end
            if (inc_full) begin
                drop_full_q <= sat_incr(drop_full_q);
            end
            if (inc_err) begin
                drop_err_q <= sat_incr(drop_err_q);
            end
        end
    end

    rx_byte_packer #(
        .data_width_p (data_width_p),
        .els_p        (els_p)
    ) u_packer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .push_i      (take),
        .start_i     (start),
        .flush_i     (flush),
        .kill_i      (kill),
        .data_i      (rx_data_i),
        .count_o     (byte_count),
        .word_v_o    (write_v_o),
        .word_addr_o (write_addr_o),
        .word_data_o (write_data_o)
    );

    assign write_slot_v_o    = commit_q;
    assign write_size_v_o    = commit_q;
    assign write_size_o      = size_q;
    assign drop_full_count_o = drop_full_q;
    assign drop_err_count_o  = drop_err_q;

endmodule

// File: doc/rx_buffer_write_ctrl.md
# rx_buffer_write_ctrl

MAC-side sequencer for the RX slot buffer memory. Accepts the MAC receive byte stream at one byte per cycle and packs it little-endian into `data_width_p` words. It writes the words into the current write slot, then commits the frame length and the slot. Frames with errors, oversize frames and frames that find no free slot are discarded without committing a slot, and each discard is counted.

## Interface
- `data_width_p`, 64, buffer word width; legal values are 32 and 64.
- `els_p`, 2048, slot size in bytes; also the maximum frame length.
- `size_width_p`, 16, width of the frame-size field.

Ports:
- `clk_i`  in  1  clock; all logic runs on this single clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `rx_v_i`  in  1  byte valid; the MAC has no backpressure.
- `rx_data_i`  in  8  received byte.
- `rx_last_i`  in  1  marks the final byte of a frame; qualified by `rx_v_i`.
- `rx_error_i`  in  1  byte is in error; qualified by `rx_v_i`.
- `write_slot_v_o`  out  1  commit pulse for the current slot.
- `write_slot_ready_and_i`  in  1  a free slot exists.
- `write_size_v_o`  out  1  frame-size write strobe.
- `write_size_o`  out  `size_width_p`  frame length in bytes.
- `write_v_o`  out  1  word write strobe.
- `write_addr_o`  out  `$clog2(els_p)`  word-aligned byte address of the write.
- `write_data_o`  out  `data_width_p`  word to write.
- `drop_full_count_o`  out  16  frames dropped because no slot was available or the block was busy; saturating.
- `drop_err_count_o`  out  16  frames dropped for error or oversize; saturating.

## Operation
- States: IDLE, RECV, LAST, COMMIT, DROP.
- IDLE, first byte with `write_slot_ready_and_i`=1:
  - go to RECV;
  - byte count becomes 1;
  - the byte is stored in lane 0.
- IDLE, first byte with `write_slot_ready_and_i`=0:
  - `drop_full_count_o` is incremented;
  - go to DROP, or stay in IDLE if the byte also has `rx_last_i`.
- Packing:
  - frame byte k goes to lane `k mod (data_width_p/8)`;
  - when a word fills, it is written at address `(k & ~(bytes_per_word-1))`;
  - unfilled lanes of the final word are written as zero.
- Sticky error flag: set by any `rx_error_i` during the frame.
- Last byte with the sticky error flag clear: the final word is written in LAST, then COMMIT.
- Last byte with the error flag set:
  - the final word is not written;
  - `drop_err_count_o` is incremented;
  - go to IDLE.
- Oversize: a byte arriving while the count equals `els_p`:
  - increment `drop_err_count_o`;
  - go to DROP, or to IDLE if that byte has `rx_last_i`.
- COMMIT:
  - `write_size_v_o`=1 and `write_slot_v_o`=1 in the same cycle;
  - `write_size_o` equals the byte count;
  - go to IDLE.
- DROP: discard bytes until a byte with `rx_last_i`, then go to IDLE.
- A dropped frame never asserts `write_slot_v_o`. The next accepted frame overwrites the same slot starting at address 0.
- Bytes arriving in LAST or COMMIT start a dropped frame:
  - `drop_full_count_o` is incremented;
  - go to DROP, unless the byte has `rx_last_i`.
- Counters saturate at 16'hFFFF.

## Timing
- All outputs are registered.
- A byte at cycle t that completes a word produces `write_v_o` at t+1, with the address and data of that word.
- Last byte at cycle t, for a good frame:
  - t+1: LAST, `write_v_o` for the final word;
  - t+2: COMMIT, size and slot pulses;
  - t+3: IDLE, the earliest cycle a new frame is accepted.
- `write_v_o`, `write_size_v_o` and `write_slot_v_o` are single-cycle pulses.
- `write_slot_ready_and_i` is sampled only on the first byte of a frame.
- Back-to-back bytes are supported; gaps in `rx_v_i` within a frame are allowed.
- Reset values:
  - state IDLE;
  - all strobes 0;
  - `write_addr_o`, `write_data_o` and `write_size_o` are 0;
  - counters 0;
  - error flag clear.
- Reset mid-frame returns the block to IDLE without a commit; the partially written slot is reused.

## Structure
- `rx_buffer_pkg` holds:
  - `rx_wr_state_e`;
  - the default `els_p`;
  - the default `size_width_p`;
  - the saturating-counter width.
- Sub-module `rx_byte_packer` holds:
  - the lane shift register;
  - the byte counter;
  - full-word and zero-fill generation.
- The parent holds the FSM and the drop counters.
- The memory's active-high reset is generated at the top level by inverting `reset_n_i`.

## Test plan
- Good frame: 64-bit width, 13-byte frame 0x01..0x0D, slot free.
  - Word at address 0 is 0x0807060504030201.
  - Word at address 8 is 0x0000000D0C0B0A09.
  - Size 13 and slot commit at last+2.
- No free slot: first byte arrives with `write_slot_ready_and_i`=0.
  - No writes and no commit.
  - `drop_full_count_o`=1.
- Error frame: 20-byte frame with `rx_error_i` on byte 5.
  - No commit; `drop_err_count_o`=1.
  - The following 4-byte frame writes address 0 and commits size 4.
- Oversize frame: a 2049-byte frame.
  - 256 words written, no commit, `drop_err_count_o`=1.
  - A 2048-byte frame commits size 2048.
- Back-to-back: a new frame starts at last+1.
  - The frame is dropped and `drop_full_count_o` increments.
  - A new frame starting at last+3 is accepted.
- Width and reset: 32-bit width, 5-byte frame; reset asserted mid-frame.
  - All outputs go to 0 and there is no commit.
  - The next frame after reset writes address 0.
